seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed 7-segment display scanner, downstream of the ALU/SPI register stage. It takes a packed vector of hex nibbles (operands/result) and drives one shared segment bus plus one-hot digit enables. Each digit is lit for a fixed dwell, with a leading anti-ghost blanking gap in every slot. Values are snapshotted once per frame so that a displayed frame never tears.

Parameters:
NUM_DIGITS, 4, number of scanned digits (legal range 1..8)
DWELL_CYCLES, 1024, clk cycles per digit slot (>= 2)
BLANK_CYCLES, 16, blanked cycles at the start of each slot (0 <= BLANK_CYCLES < DWELL_CYCLES)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  count enable; low freezes counters and holds outputs
nibbles  input  4*NUM_DIGITS  hex values; digit 0 = bits [3:0]
digit_mask  input  NUM_DIGITS  per-digit enable; 0 forces that digit dark
restart  input  1  synchronous scan restart
seg_out  output  8  {dp,g,f,e,d,c,b,a}, active-high, registered
dig_sel  output  NUM_DIGITS  one-hot digit enable, active-high, registered
frame_done  output  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset (async, rst_n=0): cnt=0, idx=0, shadow=0, seg_out=0, dig_sel=0, frame_done=0.
- Slot counter cnt runs 0..DWELL_CYCLES-1 while ena=1. At DWELL_CYCLES-1, cnt->0 and idx->idx+1.
- idx wraps from NUM_DIGITS-1 to 0. In that wrap cycle, shadow<=nibbles and frame_done=1 on the next clock, for one cycle only.
- Priority: rst_n > restart > ena.
- restart=1 (any ena): cnt=0, idx=0, shadow<=nibbles, no frame_done pulse. It holds state while asserted.
- ena=0 and restart=0: cnt, idx, shadow and outputs hold. frame_done=0.
- Output register, updated every cycle with ena=1 (1-cycle latency from cnt/idx):
  - cnt < BLANK_CYCLES: seg_out=0, dig_sel=0.
  - otherwise: dig_sel=onehot(idx) & digit_mask; seg_out = digit_mask[idx] ? decode(shadow[idx]) : 0.
- decode: standard hex 0-F glyphs with dp=0, matching the existing decoder bit order.
- BLANK_CYCLES=0: no gap. Digit switch is registered, so the output is never two-hot.
- NUM_DIGITS=1: idx constant 0. frame_done pulses every DWELL_CYCLES.
- nibbles change mid-frame: no visible effect until the next wrap or restart.
- Counter widths: $clog2(DWELL_CYCLES) for cnt and max(1,$clog2(NUM_DIGITS)) for idx. No overflow beyond the terminal value.

Optional Feature:
SEG7_SCAN_LZB_EN
- Defined: leading-zero blanking. A digit is forced dark (seg_out=0, its dig_sel bit=0) when its shadow value is 0 and every more-significant shadow digit is also 0. Digit 0 is never blanked, so value 0 shows a single "0".
- Not defined: all masked-in digits are always displayed, including leading zeros. No extra logic is compiled.

Decomposition:
- Shared package seg7_pkg: 16-entry hex glyph constant table, segment bit-index constants (SEG_A..SEG_DP), localparam helper for counter widths.
- Sub-module: reuse bin_to_7seg_decoder for the glyph lookup on the selected shadow nibble. The prescaler/slot counter stays inline.

Test Plan (DWELL_CYCLES=8, BLANK_CYCLES=2, NUM_DIGITS=4):
1. Reset/mask:
   - Stimulus: rst_n low, then release with nibbles=16'h4321, digit_mask=4'hF, restart pulse.
   - Required: seg_out=0 and dig_sel=0 during reset.
   - After restart: cycles 1-2 of slot dark; cycles 3-8 show dig_sel=0001, seg_out=8'h06 ("1"). Next slot shows dig_sel=0010, seg_out=8'h5B ("2").
2. Frame wrap:
   - Stimulus: run 32 cycles; change nibbles to 16'hFFFF mid-frame.
   - Required: display keeps showing 4321 until the wrap. frame_done pulses exactly once per 32 cycles. The next frame shows 8'h71 ("F") on all digits.
3. Mask:
   - Stimulus: digit_mask=4'b1010.
   - Required: digits 0 and 2 slots have dig_sel=0, seg_out=0. Digits 1 and 3 are normal. Slot timing is unchanged.
4. ena freeze:
   - Stimulus: drop ena for 20 cycles mid-slot.
   - Required: seg_out, dig_sel, cnt and idx are constant during the drop. Scanning resumes exactly where it stopped.
5. restart priority:
   - Stimulus: assert restart together with ena=0 at idx=2.
   - Required: next cycle idx=0, cnt=0, no frame_done pulse, shadow reloaded.
6. Leading-zero blanking (SEG7_SCAN_LZB_EN defined):
   - nibbles=16'h0050: digits 3 and 2 dark, digit 1 shows 8'h6D ("5"), digit 0 shows 8'h3F ("0").
   - nibbles=0: only digit 0 is lit, showing 8'h3F.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph table, segment bit indices and width helper for the 7-segment scanner.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Index 15 first: entry n is the {dp,g,f,e,d,c,b,a} glyph for hex digit n.
    localparam logic [15:0][7:0] HEX_GLYPHS = {
        8'h71, 8'h79, 8'h5E, 8'h39,
        8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66,
        8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bin_to_7seg_decoder.sv
// Hex nibble to {dp,g,f,e,d,c,b,a} active-high glyph, decimal point always off.
module bin_to_7seg_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bin,
    output logic [7:0] seg
);

    always_comb begin
        seg         = HEX_GLYPHS[bin];
        seg[SEG_DP] = 1'b0;
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scanner with per-frame value snapshot.
// Optional leading-zero blanking when SEG7_SCAN_LZB_EN is defined.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [4*NUM_DIGITS-1:0] nibbles,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    input  logic                    restart,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int CW = $clog2(DWELL_CYCLES);
    localparam int IW = idx_width(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    fd_q, fd_d;

    logic [3:0]            nib;
    logic [NUM_DIGITS-1:0] sel;
    logic [NUM_DIGITS-1:0] lit;
    logic [7:0]            glyph;
    logic                  blank;

    always_comb begin
        nib = 4'h0;
        sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib    = shadow_q[4*i +: 4];
                sel[i] = 1'b1;
            end
        end
    end

`ifdef SEG7_SCAN_LZB_EN
    logic zero_run;

    // Walk down from the top digit; digit 0 always stays lit.
    always_comb begin
        lit      = digit_mask;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run & (shadow_q[4*i +: 4] == 4'h0);
            if (zero_run) begin
                lit[i] = 1'b0;
            end
        end
    end
`else
    assign lit = digit_mask;
`endif

    bin_to_7seg_decoder u_dec (
        .bin (nib),
        .seg (glyph)
    );

    assign blank = int'({1'b0, cnt_q}) < BLANK_CYCLES;

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        seg_d    = seg_q;
        dig_d    = dig_q;
        fd_d     = 1'b0;
        if (restart) begin
            cnt_d    = '0;
            idx_d    = '0;
            shadow_d = nibbles;
            seg_d    = 8'h00;
            dig_d    = '0;
        end else if (ena) begin
            if (blank) begin
                seg_d = 8'h00;
                dig_d = '0;
            end else begin
                dig_d = sel & lit;
                seg_d = (|(sel & lit)) ? glyph : 8'h00;
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d    = '0;
                    shadow_d = nibbles;
                    fd_d     = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            seg_q    <= 8'h00;
            dig_q    <= '0;
            fd_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            fd_q     <= fd_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_sel    = dig_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DWELL=8, BLANK=2, four digits.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [15:0] nibbles;
    logic [3:0]  digit_mask;
    logic        restart;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (4),
        .DWELL_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .nibbles    (nibbles),
        .digit_mask (digit_mask),
        .restart    (restart),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps slot cycles from..to; cycles 1-2 are the blank gap.
    task automatic run_slot(input string tag, input int from, input int to,
                            input logic [7:0] s, input logic [3:0] d,
                            input bit wrap);
        for (int k = from; k <= to; k++) begin
            step();
            if (k <= 2)
                chk($sformatf("%s_c%0d", tag, k), {dig_sel, seg_out}, 12'h000);
            else
                chk($sformatf("%s_c%0d", tag, k), {dig_sel, seg_out}, {d, s});
            chk($sformatf("%s_fd%0d", tag, k), frame_done,
                (wrap && k == 8) ? 1 : 0);
        end
    endtask

    task automatic do_restart(input string tag);
        restart = 1'b1;
        step();
        chk({tag, "_out"}, {dig_sel, seg_out}, 12'h000);
        chk({tag, "_cnt"}, dut.cnt_q, 0);
        chk({tag, "_idx"}, dut.idx_q, 0);
        chk({tag, "_fd"}, frame_done, 0);
        restart = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b0;
        restart    = 1'b0;
        nibbles    = 16'h0000;
        digit_mask = 4'h0;
        repeat (3) step();
        chk("rst_seg", seg_out, 0);
        chk("rst_dig", dig_sel, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_cnt", dut.cnt_q, 0);

        rst_n      = 1'b1;
        nibbles    = 16'h4321;
        digit_mask = 4'hF;
        ena        = 1'b1;
        do_restart("rs1");

        run_slot("a0", 1, 8, 8'h06, 4'b0001, 0);
        run_slot("a1", 1, 8, 8'h5B, 4'b0010, 0);
        nibbles = 16'hFFFF;
        run_slot("a2", 1, 8, 8'h4F, 4'b0100, 0);
        run_slot("a3", 1, 8, 8'h66, 4'b1000, 1);

        run_slot("b0", 1, 8, 8'h71, 4'b0001, 0);
        run_slot("b1", 1, 8, 8'h71, 4'b0010, 0);
        run_slot("b2", 1, 8, 8'h71, 4'b0100, 0);
        run_slot("b3", 1, 8, 8'h71, 4'b1000, 1);

        digit_mask = 4'b1010;
        run_slot("m0", 1, 8, 8'h00, 4'b0000, 0);
        run_slot("m1", 1, 8, 8'h71, 4'b0010, 0);
        run_slot("m2", 1, 8, 8'h00, 4'b0000, 0);
        run_slot("m3", 1, 8, 8'h71, 4'b1000, 1);

        digit_mask = 4'hF;
        run_slot("f0", 1, 4, 8'h71, 4'b0001, 0);
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("frz_out%0d", i), {dig_sel, seg_out}, 12'h171);
            chk($sformatf("frz_fd%0d", i), frame_done, 0);
            chk($sformatf("frz_cnt%0d", i), dut.cnt_q, 4);
            chk($sformatf("frz_idx%0d", i), dut.idx_q, 0);
        end
        ena = 1'b1;
        run_slot("f0r", 5, 8, 8'h71, 4'b0001, 0);
        run_slot("f1", 1, 8, 8'h71, 4'b0010, 0);
        run_slot("f2", 1, 5, 8'h71, 4'b0100, 0);
        chk("pre_rs_idx", dut.idx_q, 2);

        nibbles = 16'hA987;
        ena     = 1'b0;
        do_restart("rs2");
        ena = 1'b1;
        run_slot("e0", 1, 8, 8'h07, 4'b0001, 0);
        run_slot("e1", 1, 8, 8'h7F, 4'b0010, 0);
        run_slot("e2", 1, 8, 8'h6F, 4'b0100, 0);
        run_slot("e3", 1, 8, 8'h77, 4'b1000, 1);

        nibbles = 16'h0050;
        do_restart("rs3");
        run_slot("z0", 1, 8, 8'h3F, 4'b0001, 0);
        run_slot("z1", 1, 8, 8'h6D, 4'b0010, 0);
`ifdef SEG7_SCAN_LZB_EN
        run_slot("z2", 1, 8, 8'h00, 4'b0000, 0);
        run_slot("z3", 1, 8, 8'h00, 4'b0000, 1);
`else
        run_slot("z2", 1, 8, 8'h3F, 4'b0100, 0);
        run_slot("z3", 1, 8, 8'h3F, 4'b1000, 1);
`endif

        nibbles = 16'h0000;
        do_restart("rs4");
        run_slot("n0", 1, 8, 8'h3F, 4'b0001, 0);
`ifdef SEG7_SCAN_LZB_EN
        run_slot("n1", 1, 8, 8'h00, 4'b0000, 0);
        run_slot("n2", 1, 8, 8'h00, 4'b0000, 0);
        run_slot("n3", 1, 8, 8'h00, 4'b0000, 1);
`else
        run_slot("n1", 1, 8, 8'h3F, 4'b0010, 0);
        run_slot("n2", 1, 8, 8'h3F, 4'b0100, 0);
        run_slot("n3", 1, 8, 8'h3F, 4'b1000, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
